muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit, parametrised in XLEN, sitting beside the single-cycle ALU in EX. It takes funct3 of an opcode 0110011 / funct7 0000001 instruction plus two operands and runs a multi-cycle shift-add multiply or restoring divide. It exposes a valid/ready handshake so the hazard unit stalls the pipeline while busy, and a flush input for branch/exception squash.

Parameters:
XLEN, 32, operand/result width; any value >= 4.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
valid_i  in  1  request valid; sampled only when ready_o=1.
ready_o  out  1  unit idle and able to accept a request.
funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op1_i  in  XLEN  rs1 value (multiplicand / dividend).
op2_i  in  XLEN  rs2 value (multiplier / divisor).
flush_i  in  1  abort any in-flight operation.
valid_o  out  1  one-cycle pulse: result_o is valid this cycle.
result_o  out  XLEN  registered result; holds last value until the next completion.
busy_o  out  1  equals ~ready_o.

Behaviour:
- Reset, asynchronous and immediate: state=IDLE, ready_o=1, busy_o=0, valid_o=0, result_o=0, all internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE: accept when valid_i & ready_o & ~flush_i. Latch funct3, take absolute values per signedness, record result sign, counter=XLEN. Then go to CALC, or straight to DONE on a fast path.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats op1 signed, op2 unsigned. MULHU/DIVU/REMU treat both unsigned.
- CALC: one radix-2 step per cycle, counter decrements; on the cycle counter reaches 1 the next state is DONE.
  - Multiply: 2*XLEN product register, shift-add.
  - Divide: restoring; XLEN-bit quotient and XLEN+1-bit partial remainder.
- DONE: apply sign correction (two's-complement negate of product, quotient or remainder), select the field, register result_o, pulse valid_o for exactly 1 cycle, return to IDLE. ready_o=1 again the cycle after valid_o.
- Result selection: MUL returns product[XLEN-1:0]. MULH/MULHSU/MULHU return product[2XLEN-1:XLEN]. DIV/DIVU return the quotient. REM/REMU return the remainder.
- Sign rules: product sign = s1 xor s2; quotient sign = s1 xor s2; remainder sign = dividend sign.
- Latency: accept in cycle n gives valid_o in cycle n+XLEN+1. No early termination except the fast paths.
- Fast paths (valid_o in cycle n+1, CALC skipped):
  - Divisor 0: quotient = all ones (DIV and DIVU); remainder = op1 unchanged.
  - Signed overflow, DIV/REM with op1 = 1 followed by XLEN-1 zeros and op2 = all ones: quotient = op1, remainder = 0.
- flush_i=1 in any state: next state IDLE, valid_o=0 next cycle, result_o unchanged, the aborted operation never reports.
- flush_i=1 together with valid_i in IDLE: flush wins and the request is not accepted.
- valid_i while busy is ignored; the requester must hold it until ready_o.
- Operand/funct3 inputs may change after acceptance without effect.
- Reset asserted mid-operation returns everything to reset values without waiting for a clock edge.

Decomposition:
- Shared package (muldiv_pkg): funct3 localparams (F3_MUL to F3_REMU), state encoding localparams, helper function is_signed_op.
- One natural sub-module, muldiv_step: combinational single iteration (shift-add or restore-subtract selected by a mode bit). The top keeps the FSM, counter, sign fix-up and output registers.

Test Plan (XLEN=32):
- MUL 7 x 0xFFFFFFFD (-3), accepted cycle n -> valid_o only at n+33, result_o=0xFFFFFFEB; ready_o=0 from n+1 to n+33, ready_o=1 at n+34.
- High products:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - REMU same operands -> 1.
- Divide by zero:
  - DIV 5 / 0 -> 0xFFFFFFFF at n+1.
  - REMU 5 / 0 -> 5 at n+1.
  - Overflow DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both at n+1.
- flush_i pulsed at n+10 of a DIV -> no valid_o ever for that op, ready_o=1 at n+11, result_o unchanged. flush_i with valid_i in IDLE -> request not accepted, ready_o stays 1.
- rst_i asserted asynchronously at n+5 of a MUL -> ready_o=1, valid_o=0, result_o=0 before the next clock edge. After release, a new MUL 3 x 4 -> 12 with normal latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and operand-signedness helper.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // is_rs2=0 asks about op1, is_rs2=1 about op2; MULHSU is signed on op1 only.
  function automatic logic is_signed_op(input logic [2:0] f3, input logic is_rs2);
    if (is_rs2)
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    else
      return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// acc = product high half / partial remainder, low = multiplier / dividend-quotient.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_low,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_low
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  assign w_sum   = {1'b0, i_acc} + (i_low[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
  assign w_shift = {i_acc, i_low[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, i_opnd});
  // When w_ge holds the true difference is below the divisor, so XLEN bits suffice.
  assign w_diff  = w_shift[XLEN-1:0] - i_opnd;

  always_comb begin
    o_acc = w_sum[XLEN:1];
    o_low = {w_sum[0], i_low[XLEN-1:1]};
    if (i_div) begin
      o_acc = w_ge ? w_diff : w_shift[XLEN-1:0];
      o_low = {i_low[XLEN-2:0], w_ge};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude datapath with sign fix-up,
// valid/ready handshake, divide-by-zero / overflow fast paths and flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_low;
  logic [XLEN-1:0]   r_opnd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_result;

  logic              w_s1;
  logic              w_s2;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic              w_accept;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_last;
  logic [XLEN-1:0]   w_acc_next;
  logic [XLEN-1:0]   w_low_next;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_final;

  assign w_s1     = is_signed_op(funct3_i, 1'b0) & op1_i[XLEN-1];
  assign w_s2     = is_signed_op(funct3_i, 1'b1) & op2_i[XLEN-1];
  assign w_abs1   = w_s1 ? -op1_i : op1_i;
  assign w_abs2   = w_s2 ? -op2_i : op2_i;
  assign w_accept = (r_state == S_IDLE) & valid_i & ~flush_i;
  assign w_div0   = funct3_i[2] & (op2_i == '0);
  assign w_ovf    = funct3_i[2] & is_signed_op(funct3_i, 1'b1)
                  & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&op2_i);
  assign w_fast   = w_div0 | w_ovf;
  assign w_last   = (r_state == S_CALC) & (r_cnt == CNT_W'(1));

  // funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
  always_comb begin
    w_fast_res = funct3_i[1] ? {XLEN{1'b0}} : op1_i;
    if (w_div0)
      w_fast_res = funct3_i[1] ? op1_i : {XLEN{1'b1}};
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_div  (r_f3[2]),
    .i_acc  (r_acc),
    .i_low  (r_low),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_next),
    .o_low  (w_low_next)
  );

  assign w_prod_fix = r_neg_q ? -{w_acc_next, w_low_next} : {w_acc_next, w_low_next};
  assign w_quo_fix  = r_neg_q ? -w_low_next : w_low_next;
  assign w_rem_fix  = r_neg_r ? -w_acc_next : w_acc_next;

  always_comb begin
    w_final = w_rem_fix;
    case (r_f3)
      F3_MUL:                       w_final = w_prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_final = w_quo_fix;
      default:                      w_final = w_rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_fast ? S_DONE : S_CALC;
      S_CALC:  if (w_last)   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush_i) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_f3     <= '0;
      r_acc    <= '0;
      r_low    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_f3    <= funct3_i;
      r_acc   <= '0;
      r_low   <= w_abs1;
      r_opnd  <= w_abs2;
      r_cnt   <= CNT_W'(XLEN);
      r_neg_q <= w_s1 ^ w_s2;
      r_neg_r <= w_s1;
      if (w_fast) r_result <= w_fast_res;
    end else if ((r_state == S_CALC) && !flush_i) begin
      r_acc <= w_acc_next;
      r_low <= w_low_next;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) r_result <= w_final;
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign busy_o   = ~ready_o;
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32): latency, results, fast paths,
// flush behaviour and asynchronous reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] result_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .funct3_i (funct3_i),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble inputs after acceptance, then time the result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int rdy_hi;
    lat = 0;
    rdy_hi = 0;
    @(negedge clk_i);
    funct3_i = f3; op1_i = a; op2_i = b; valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i  = 1'b0;
    op1_i    = $urandom;
    op2_i    = $urandom;
    funct3_i = 3'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (valid_o) begin
        lat = k;
        break;
      end
      if (ready_o) rdy_hi++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    check({tag, " ready low while busy"}, 32'(rdy_hi), 32'd0);
    check({tag, " busy at valid"}, {31'd0, busy_o}, 32'd1);
    $display("[TB] %s f3=%0d a=%h b=%h -> result=%h latency=%0d", tag, f3, a, b, result_o, lat);
    @(negedge clk_i);
    check({tag, " valid one cycle"}, {31'd0, valid_o}, 32'd0);
    check({tag, " ready after valid"}, {31'd0, ready_o}, 32'd1);
  endtask

  initial begin
    int seen;
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'd0; op1_i = '0; op2_i = '0;
    #12;
    check("reset ready", {31'd0, ready_o}, 32'd1);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset valid", {31'd0, valid_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op("MUL 7*-3",      F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("MULH min*min",  F3_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33);
    run_op("MULHU max*max", F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("MULHSU -1*max", F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("DIV -7/2",      F3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33);
    run_op("REM -7/2",      F3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33);
    run_op("DIVU big/2",    F3_DIVU,   32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 33);
    run_op("REMU big/2",    F3_REMU,   32'hFFFFFFF9,   32'd2,        32'd1,        33);
    run_op("DIV 5/0",       F3_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1);
    run_op("REMU 5/0",      F3_REMU,   32'd5,          32'd0,        32'd5,        1);
    run_op("DIVU 5/0",      F3_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1);
    run_op("REM -7/0",      F3_REM,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 1);
    run_op("DIV overflow",  F3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM overflow",  F3_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1);
    run_op("DIVU 100/7",    F3_DIVU,   32'd100,        32'd7,        32'd14,       33);

    // Flush a divide mid-flight.
    @(negedge clk_i);
    funct3_i = F3_DIV; op1_i = 32'd1000; op2_i = 32'd3; valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("flush busy before", {31'd0, ready_o}, 32'd0);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush ready next", {31'd0, ready_o}, 32'd1);
    check("flush result held", result_o, 32'd14);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    check("flush no valid", 32'(seen), 32'd0);
    check("flush result still held", result_o, 32'd14);
    $display("[TB] flush DIV 1000/3 at n+10 -> valid pulses=%0d result=%h", seen, result_o);

    // Flush together with a request in IDLE.
    @(negedge clk_i);
    funct3_i = F3_MUL; op1_i = 32'd9; op2_i = 32'd9; valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    check("flush+valid ready", {31'd0, ready_o}, 32'd1);
    valid_i = 1'b0; flush_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o || !ready_o) seen++;
    end
    check("flush+valid not accepted", 32'(seen), 32'd0);
    $display("[TB] flush with valid in IDLE -> busy/valid cycles=%0d", seen);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk_i);
    funct3_i = F3_MUL; op1_i = 32'd5; op2_i = 32'd6; valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("async rst ready", {31'd0, ready_o}, 32'd1);
    check("async rst busy", {31'd0, busy_o}, 32'd0);
    check("async rst valid", {31'd0, valid_o}, 32'd0);
    check("async rst result", result_o, 32'd0);
    $display("[TB] async reset mid-MUL -> ready=%0d valid=%0d result=%h", ready_o, valid_o, result_o);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_op("MUL 3*4 after rst", F3_MUL, 32'd3, 32'd4, 32'd12, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
